// File: rtl/npc_mem_pkg.sv
// Shared definitions for the npc memory-port arbiter: access masks, FSM states
// and requester ids.
package npc_mem_pkg;

    localparam logic [3:0] MASK_D = 4'b0001;
    localparam logic [3:0] MASK_W = 4'b0010;
    localparam logic [3:0] MASK_H = 4'b0100;
    localparam logic [3:0] MASK_B = 4'b1000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational alignment check: a one-hot size mask against the low address bits.
// Any mask that is not one-hot is reported as not ok.
module mem_align_chk
    import npc_mem_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [2:0] addr_lo,
    output logic       ok
);

    always_comb begin
        ok = 1'b0;
        case (mask)
            MASK_D:  ok = (addr_lo == 3'b000);
            MASK_W:  ok = (addr_lo[1:0] == 2'b00);
            MASK_H:  ok = !addr_lo[0];
            MASK_B:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single mem port between IFU and LSU: one access in flight,
// LSU preferred, IFU promoted after STARVE_LIMIT consecutive losses.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [3:0]  lsu_mem_mask,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_ena,
    output logic        mem_wen,
    output logic [3:0]  mem_mem_mask,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    logic [CntW-1:0] starve_cnt_q;
    logic        owner_q, wen_q, err_q;
    logic [3:0]  mask_q;
    logic [63:0] addr_q, wdata_q, rdata_q;

    logic starve_hit, ifu_wins, lsu_wins, idle, ifu_hs, lsu_hs, resp_ready_sel, ok;
    logic in_access, in_resp;

    mem_align_chk u_align_chk (
        .mask    (mask_q),
        .addr_lo (addr_q[2:0]),
        .ok      (ok)
    );

    always_comb begin
        starve_hit = (starve_cnt_q == Limit);
        ifu_wins   = ifu_req_valid && (starve_hit || !lsu_req_valid);
        lsu_wins   = lsu_req_valid && !(starve_hit && ifu_req_valid);
        // No grant while reset is asserted, so nothing is handshaken and dropped.
        idle       = (state_q == StIdle) && !rst;
        ifu_req_ready = idle && ifu_wins;
        lsu_req_ready = idle && lsu_wins;
        ifu_hs = ifu_req_valid && ifu_req_ready;
        lsu_hs = lsu_req_valid && lsu_req_ready;
        resp_ready_sel = (owner_q == REQ_LSU) ? lsu_resp_ready : ifu_resp_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (ifu_hs || lsu_hs) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (resp_ready_sel) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            owner_q      <= REQ_IFU;
            wen_q        <= 1'b0;
            mask_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ifu_hs || lsu_hs) begin
                owner_q <= lsu_hs ? REQ_LSU : REQ_IFU;
                wen_q   <= lsu_hs && lsu_wen;
                mask_q  <= lsu_hs ? lsu_mem_mask : MASK_W;
                addr_q  <= lsu_hs ? lsu_addr : ifu_addr;
                wdata_q <= lsu_hs ? lsu_wdata : '0;
            end
            if (state_q == StAccess) begin
                rdata_q <= (ok && !wen_q) ? mem_rdata : '0;
                err_q   <= !ok;
            end
            if (ifu_hs) begin
                starve_cnt_q <= '0;
            end else if (lsu_hs && ifu_req_valid && !starve_hit) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_access    = (state_q == StAccess);
        in_resp      = (state_q == StResp);
        mem_ena      = in_access && ok;
        mem_wen      = mem_ena && wen_q;
        mem_mem_mask = in_access ? mask_q : '0;
        mem_addr     = in_access ? addr_q : '0;
        mem_wdata    = in_access ? wdata_q : '0;

        ifu_resp_valid = in_resp && (owner_q == REQ_IFU);
        ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
        ifu_err        = ifu_resp_valid && err_q;
        lsu_resp_valid = in_resp && (owner_q == REQ_LSU);
        lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
        lsu_err        = lsu_resp_valid && err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small byte-array memory model.
module tb_mem_arbiter;
    import npc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
    logic [3:0]  lsu_mem_mask;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_ena, mem_wen;
    logic [3:0]  mem_mem_mask;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem_bytes [0:255];
    int          ena_count = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_rdata      (ifu_rdata),
        .ifu_err        (ifu_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_mem_mask   (lsu_mem_mask),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_rdata      (lsu_rdata),
        .lsu_err        (lsu_err),
        .mem_ena        (mem_ena),
        .mem_wen        (mem_wen),
        .mem_mem_mask   (mem_mem_mask),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    function automatic int nbytes(input logic [3:0] m);
        case (m)
            4'b0001: return 8;
            4'b0010: return 4;
            4'b0100: return 2;
            4'b1000: return 1;
            default: return 0;
        endcase
    endfunction

    // Memory model: returns data already right-aligned, little-endian.
    always_comb begin
        logic [7:0] idx;
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            idx = mem_addr[7:0] + 8'(i);
            if (i < nbytes(mem_mem_mask)) mem_rdata[i*8 +: 8] = mem_bytes[idx];
        end
    end

    always @(posedge clk) begin
        logic [7:0] widx;
        if (mem_ena) begin
            ena_count <= ena_count + 1;
            if (mem_wen) begin
                for (int i = 0; i < 8; i++) begin
                    widx = mem_addr[7:0] + 8'(i);
                    if (i < nbytes(mem_mem_mask)) mem_bytes[widx] <= mem_wdata[i*8 +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_mem_mask = '0; lsu_addr = '0; lsu_wdata = '0;
        lsu_resp_ready = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        outs = {ifu_req_ready, ifu_resp_valid, ifu_err, lsu_req_ready, lsu_resp_valid, lsu_err,
                mem_ena, mem_wen, mem_mem_mask};
        total++;
        if (outs !== 64'd0) begin
            bad++; $display("FAIL reset_ctrl got=%0h want=0", outs);
        end
        total++;
        if ((ifu_rdata | lsu_rdata | mem_addr | mem_wdata) !== 64'd0) begin
            bad++; $display("FAIL reset_data got=%0h/%0h/%0h/%0h want=0",
                            ifu_rdata, lsu_rdata, mem_addr, mem_wdata);
        end
        total++;
        if (dut.state_q !== StIdle || dut.starve_cnt_q !== 3'd0) begin
            bad++; $display("FAIL reset_state got=%0d/%0d want=0/0", dut.state_q, dut.starve_cnt_q);
        end
    endtask

    task automatic test_ifu_read();
        int ena0 = ena_count;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 0;
        #1;
        total++;
        if (ifu_req_ready !== 1'b1) begin
            bad++; $display("FAIL ifu_ready got=%b want=1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 0;
        #1;
        total++;
        if ({mem_ena, mem_wen, mem_mem_mask, ifu_resp_valid} !== 7'b1_0_0010_0
            || mem_addr !== 64'h8000_0000) begin
            bad++; $display("FAIL ifu_access got=%b/%b/%b/%b/%0h want=1/0/0010/0/80000000",
                            mem_ena, mem_wen, mem_mem_mask, ifu_resp_valid, mem_addr);
        end
        tick();
        total++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 64'h0000_0000_0013_0513 || ifu_err !== 1'b0
            || mem_ena !== 1'b0) begin
            bad++; $display("FAIL ifu_resp got=%b/%0h/%b ena=%b want=1/130513/0 ena=0",
                            ifu_resp_valid, ifu_rdata, ifu_err, mem_ena);
        end
        ifu_resp_ready = 1;
        tick();
        ifu_resp_ready = 0;
        total++;
        if (ifu_resp_valid !== 1'b0 || ena_count - ena0 != 1) begin
            bad++; $display("FAIL ifu_done got=%b/%0d want=0/1", ifu_resp_valid, ena_count - ena0);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] exp_ifu = 10'b10_0001_0000;
        int exp_cnt;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 1;
        lsu_req_valid = 1; lsu_wen = 0; lsu_mem_mask = MASK_D; lsu_addr = 64'h8000_0008;
        lsu_resp_ready = 1;
        #1;
        for (int k = 0; k < 10; k++) begin
            int w = 0;
            while (!(ifu_req_ready || lsu_req_ready) && w < 6) begin
                tick();
                w++;
            end
            total++;
            if (!(ifu_req_ready || lsu_req_ready)) begin
                bad++; $display("FAIL starve_timeout got=none want=grant%0d", k);
            end else begin
                exp_cnt = (k < 5) ? k : k - 5;
                if (ifu_req_ready !== exp_ifu[k] || dut.starve_cnt_q !== 3'(exp_cnt)) begin
                    bad++; $display("FAIL starve_grant%0d got=ifu%b cnt%0d want=ifu%b cnt%0d",
                                    k, ifu_req_ready, dut.starve_cnt_q, exp_ifu[k], exp_cnt);
                end
                tick();
                if (exp_ifu[k]) begin
                    total++;
                    if (dut.starve_cnt_q !== 3'd0) begin
                        bad++; $display("FAIL starve_clear got=%0d want=0", dut.starve_cnt_q);
                    end
                end
            end
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick(); tick(); tick();
        ifu_resp_ready = 0; lsu_resp_ready = 0;
    endtask

    task automatic test_store_byte();
        lsu_req_valid = 1; lsu_wen = 1; lsu_mem_mask = MASK_B; lsu_addr = 64'h8000_0003;
        lsu_wdata = 64'hAB; lsu_resp_ready = 0;
        #1;
        total++;
        if (lsu_req_ready !== 1'b1) begin
            bad++; $display("FAIL sb_ready got=%b want=1", lsu_req_ready);
        end
        tick();
        lsu_req_valid = 0;
        #1;
        total++;
        if ({mem_ena, mem_wen, mem_mem_mask} !== 6'b11_1000 || mem_addr !== 64'h8000_0003
            || mem_wdata !== 64'hAB) begin
            bad++; $display("FAIL sb_access got=%b%b/%b/%0h/%0h want=11/1000/80000003/ab",
                            mem_ena, mem_wen, mem_mem_mask, mem_addr, mem_wdata);
        end
        tick();
        total++;
        if (mem_bytes[3] !== 8'hAB || lsu_resp_valid !== 1'b1 || lsu_rdata !== 64'd0
            || lsu_err !== 1'b0) begin
            bad++; $display("FAIL sb_resp got=%0h/%b/%0h/%b want=ab/1/0/0",
                            mem_bytes[3], lsu_resp_valid, lsu_rdata, lsu_err);
        end
        lsu_resp_ready = 1;
        tick();
        lsu_resp_ready = 0; lsu_wen = 0;
    endtask

    task automatic test_misaligned();
        logic [3:0]  masks [2] = '{MASK_W, 4'b0110};
        logic [63:0] addrs [2] = '{64'h8000_0002, 64'h8000_0000};
        for (int c = 0; c < 2; c++) begin
            int ena0 = ena_count;
            lsu_req_valid = 1; lsu_wen = 0; lsu_mem_mask = masks[c]; lsu_addr = addrs[c];
            lsu_resp_ready = 0;
            tick();
            lsu_req_valid = 0;
            #1;
            total++;
            if (mem_ena !== 1'b0) begin
                bad++; $display("FAIL misal%0d_ena got=%b want=0", c, mem_ena);
            end
            tick();
            total++;
            if (lsu_resp_valid !== 1'b1 || lsu_err !== 1'b1 || lsu_rdata !== 64'd0
                || ena_count != ena0) begin
                bad++; $display("FAIL misal%0d_resp got=%b/%b/%0h/%0d want=1/1/0/0", c,
                                lsu_resp_valid, lsu_err, lsu_rdata, ena_count - ena0);
            end
            lsu_resp_ready = 1;
            tick();
            lsu_resp_ready = 0;
        end
    endtask

    task automatic test_back_pressure();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 0;
        tick();
        ifu_req_valid = 0;
        lsu_req_valid = 1; lsu_wen = 0; lsu_mem_mask = MASK_D; lsu_addr = 64'h8000_0000;
        lsu_resp_ready = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 64'h0000_0000_AB13_0513
                || lsu_req_ready !== 1'b0 || mem_ena !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%0h/%b/%b want=1/ab130513/0/0", i,
                                ifu_resp_valid, ifu_rdata, lsu_req_ready, mem_ena);
            end
            tick();
        end
        ifu_resp_ready = 1;
        tick();
        ifu_resp_ready = 0;
        total++;
        if (lsu_req_ready !== 1'b1) begin
            bad++; $display("FAIL bp_lsu_grant got=%b want=1", lsu_req_ready);
        end
        tick();
        lsu_req_valid = 0;
        #1;
        total++;
        if (mem_ena !== 1'b1 || mem_mem_mask !== MASK_D) begin
            bad++; $display("FAIL bp_lsu_access got=%b/%b want=1/0001", mem_ena, mem_mem_mask);
        end
        tick();
        total++;
        if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 64'h0000_0000_AB13_0513) begin
            bad++; $display("FAIL bp_lsu_resp got=%b/%0h want=1/ab130513",
                            lsu_resp_valid, lsu_rdata);
        end
        lsu_resp_ready = 1;
        tick();
        lsu_resp_ready = 0;
    endtask

    task automatic test_reset_mid();
        lsu_req_valid = 1; lsu_wen = 1; lsu_mem_mask = MASK_D; lsu_addr = 64'h8000_0010;
        lsu_wdata = 64'h1122_3344_5566_7788; lsu_resp_ready = 1;
        tick();
        lsu_req_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        total++;
        if ({mem_ena, mem_wen, mem_mem_mask, lsu_resp_valid, lsu_err, ifu_resp_valid,
             lsu_req_ready, ifu_req_ready} !== 11'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0
            || lsu_rdata !== 64'd0 || dut.state_q !== StIdle) begin
            bad++; $display("FAIL rst_mid got=ena%b wen%b rv%b st%0d want=0/0/0/0",
                            mem_ena, mem_wen, lsu_resp_valid, dut.state_q);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (lsu_resp_valid !== 1'b0) begin
                bad++; $display("FAIL rst_no_resp%0d got=%b want=0", i, lsu_resp_valid);
            end
        end
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 1;
        tick();
        ifu_req_valid = 0;
        #1;
        total++;
        if (mem_ena !== 1'b1 || mem_mem_mask !== MASK_W) begin
            bad++; $display("FAIL rst_ifu_access got=%b/%b want=1/0010", mem_ena, mem_mem_mask);
        end
        tick();
        total++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 64'h0000_0000_AB13_0513 || ifu_err !== 1'b0)
        begin
            bad++; $display("FAIL rst_ifu_resp got=%b/%0h/%b want=1/ab130513/0",
                            ifu_resp_valid, ifu_rdata, ifu_err);
        end
        tick();
        ifu_resp_ready = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'h00;
        mem_bytes[0] = 8'h13; mem_bytes[1] = 8'h05; mem_bytes[2] = 8'h13; mem_bytes[3] = 8'h00;
        test_reset();
        test_ifu_read();
        test_starvation();
        test_store_byte();
        test_misaligned();
        test_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single `mem` DPI memory port between instruction fetch (IFU) and load/store unit (LSU) in the npc core. Accepts one request at a time over valid/ready handshakes and grants LSU by default, with a starvation guard for IFU. Drives the mem port for exactly one cycle per access and holds the response until the requester accepts it. Rejects misaligned or ill-formed accesses without touching memory.

## Interface
- `STARVE_LIMIT`, 4: consecutive arbitration losses after which a waiting IFU wins over LSU (≥1).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1: IFU request handshake; IFU accesses are reads with mask 4'b0010.
- `ifu_addr` in 64: fetch address.
- `ifu_resp_valid` out 1 / `ifu_resp_ready` in 1: IFU response handshake.
- `ifu_rdata` out 64, `ifu_err` out 1: fetch data; misalignment flag.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1: LSU request handshake.
- `lsu_wen` in 1, `lsu_mem_mask` in 4, `lsu_addr` in 64, `lsu_wdata` in 64: access type, size, address, store data.
- `lsu_resp_valid` out 1 / `lsu_resp_ready` in 1: LSU response handshake; writes also get a response.
- `lsu_rdata` out 64, `lsu_err` out 1: load data (0 for stores); error flag.
- `mem_ena` out 1, `mem_wen` out 1, `mem_mem_mask` out 4, `mem_addr` out 64, `mem_wdata` out 64: mem port drive.
- `mem_rdata` in 64: mem read data, already masked and right-shifted by mem.

## Operation
- Mask encoding, one-hot: 4'b0001 dword, 4'b0010 word, 4'b0100 half, 4'b1000 byte.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `*_req_ready` high only for the combinational winner. LSU wins unless `starve_cnt == STARVE_LIMIT` and IFU is valid. A handshake latches requester id, wen, mask, addr, and wdata, then moves to ACCESS.
- Alignment check on the latched request. OK when: dword needs addr[2:0]=0; word needs addr[1:0]=0; half needs addr[0]=0; byte is always OK. A mask that is not one-hot is an error.
- ACCESS, lasts one cycle:
  - If OK: `mem_ena`=1, mem_* driven from the latch, `mem_rdata` captured into the response register. For writes, the response data is 0.
  - If not OK: `mem_ena`=0, response data 0, error flag set.
  - Always moves to RESP.
- RESP: the owner's `*_resp_valid`=1; rdata and err held stable. When `resp_ready`=1, move to IDLE.
- `starve_cnt`:
  - +1 in IDLE when both are valid and LSU is granted.
  - Cleared when IFU is granted.
  - Saturates at STARVE_LIMIT.
  - Holds otherwise.
- No sign/zero extension here; the LSU extends.

## Timing
- Reset values: all `*_ready`, `*_resp_valid`, `*_err`, and `mem_ena`/`mem_wen` are 0. All data/addr/mask outputs are 0. FSM is in IDLE and `starve_cnt`=0.
- Handshake at edge N ⇒ `mem_ena` high during cycle N+1 only ⇒ `resp_valid` from cycle N+2.
- Minimum interval between grants is 3 cycles. No request is accepted while in ACCESS or RESP.
- `mem_ena`, `mem_wen`, and `mem_addr` are 0 outside ACCESS; `mem_wen` is additionally gated by `mem_ena`.
- `resp_ready` held low keeps the FSM in RESP indefinitely, with outputs stable.
- A requester must hold valid and payload stable until ready. The arbiter never drops a granted request, except on reset.
- `rst` in any state: at the next edge, state goes to IDLE, the in-flight request and response are discarded, and all outputs return to reset values.
- Simultaneous IFU and LSU valid, counter below limit: LSU is granted and the counter increments in the same edge.

## Structure
- Shared package `npc_mem_pkg` holds:
  - mask constants `MASK_D/W/H/B`
  - FSM state enum
  - requester id constants (IFU=0, LSU=1)
- Sub-module `mem_align_chk`: combinational mask + addr[2:0] → ok. Reused later by the LSU exception logic.

## Test plan
- IFU read 0x8000_0000, model word 0x0000_0000_0013_0513: `mem_ena` high one cycle with mask 0010, then `ifu_resp_valid` 2 cycles after the handshake with that rdata and `ifu_err`=0.
- Both requesters continuously valid, STARVE_LIMIT=4: grants go LSU×4, IFU, LSU×4, IFU. `starve_cnt` reaches 4 and clears on the IFU grant.
- LSU store-byte at 0x8000_0003, mask 1000, wdata 0xAB: one-cycle `mem_ena`=`mem_wen`=1 with addr/mask/wdata passed through. Model byte 3 = 0xAB, `lsu_resp_valid` with rdata 0 and err 0.
- LSU load-word at 0x8000_0002 (misaligned), and separately mask 0110: `mem_ena` never asserted, `lsu_err`=1, `lsu_rdata`=0.
- `ifu_resp_ready` low for 3 cycles while LSU is valid: `ifu_resp_valid`/`rdata` stay stable, `lsu_req_ready`=0, no `mem_ena`. LSU is granted the cycle after IFU accepts.
- `rst` pulsed during ACCESS of an LSU write: all outputs 0 at the next edge, no response is ever issued, FSM is in IDLE, and a fresh IFU request is then serviced normally.
